// File: rtl/data_mem_responder_if.sv
// Request/response bundle between the core's data port and the memory responder.
// The master drives the request fields; the slave returns ready/rdata/error.
interface data_mem_responder_if;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        ready;
  logic [31:0] rdata;
  logic        error;

  modport master (output req, we, addr, wdata, input ready, rdata, error);
  modport slave  (input req, we, addr, wdata, output ready, rdata, error);
endinterface

// File: rtl/data_mem_responder.sv
// Word-addressed data RAM behind a req/ready handshake, with a programmable number of wait states.
// Handles one access at a time and rejects misaligned or out-of-range addresses.
module data_mem_responder #(
  parameter int ADDR_WIDTH  = 8,
  parameter int WAIT_CYCLES = 2
) (
  input  logic                clk,
  input  logic                reset,
  data_mem_responder_if.slave bus
);

  localparam int             DEPTH     = 1 << ADDR_WIDTH;
  localparam logic [7:0]     WAIT_INIT = 8'(WAIT_CYCLES);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic [7:0]              r_count;
  logic                    r_we;
  logic [31:0]             r_addr;
  logic [31:0]             r_wdata;
  logic                    r_ready;
  logic                    r_error;
  logic [31:0]             r_rdata;
  logic [31:0]             r_mem [DEPTH];

  logic                    w_acc_we;
  logic [31:0]             w_acc_addr;
  logic [31:0]             w_acc_wdata;
  logic                    w_enter_resp;
  logic                    w_misalign;
  logic                    w_oor;
  logic                    w_err;
  logic [ADDR_WIDTH-1:0]   w_idx;
  logic                    w_mem_we;

  // Next-state decode: IDLE waits for req, WAIT counts down, RESP lasts one cycle.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (bus.req) begin
          w_state_nxt = (WAIT_CYCLES > 0) ? S_WAIT : S_RESP;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_WAIT: begin
        if (r_count <= 8'd1) begin
          w_state_nxt = S_RESP;
        end else begin
          w_state_nxt = S_WAIT;
        end
      end
      S_RESP:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Access decode; with zero wait states the access runs on the accepting edge, so it uses the live bus.
  always_comb begin
    w_acc_we    = r_we;
    w_acc_addr  = r_addr;
    w_acc_wdata = r_wdata;
    if (r_state == S_IDLE) begin
      w_acc_we    = bus.we;
      w_acc_addr  = bus.addr;
      w_acc_wdata = bus.wdata;
    end else begin
      w_acc_we    = r_we;
      w_acc_addr  = r_addr;
      w_acc_wdata = r_wdata;
    end
    w_enter_resp = (w_state_nxt == S_RESP) && (r_state != S_RESP);
    w_misalign   = (w_acc_addr[1:0] != 2'b00);
    w_oor        = ((w_acc_addr >> (ADDR_WIDTH + 2)) != 32'd0);
    w_err        = w_misalign || w_oor;
    w_idx        = w_acc_addr[ADDR_WIDTH+1:2];
    w_mem_we     = w_enter_resp && w_acc_we && !w_err && !reset;
  end

  // State, latched request, wait counter and registered response outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_count <= 8'd0;
      r_we    <= 1'b0;
      r_addr  <= 32'd0;
      r_wdata <= 32'd0;
      r_ready <= 1'b0;
      r_error <= 1'b0;
      r_rdata <= 32'd0;
    end else begin
      r_state <= w_state_nxt;
      if ((r_state == S_IDLE) && bus.req) begin
        r_we    <= bus.we;
        r_addr  <= bus.addr;
        r_wdata <= bus.wdata;
        r_count <= WAIT_INIT;
      end else if (r_state == S_WAIT) begin
        r_count <= r_count - 8'd1;
      end
      r_ready <= w_enter_resp;
      r_error <= w_enter_resp && w_err;
      if (w_enter_resp && w_err) begin
        r_rdata <= 32'd0;
      end else if (w_enter_resp && !w_acc_we) begin
        r_rdata <= r_mem[w_idx];
      end
    end
  end

  // RAM array is deliberately outside reset so contents survive a reset.
  always_ff @(posedge clk) begin
    if (w_mem_we) begin
      r_mem[w_idx] <= w_acc_wdata;
    end
  end

  assign bus.ready = r_ready;
  assign bus.error = r_error;
  assign bus.rdata = r_rdata;

endmodule
